// File: rtl/pwm_from_count.sv
// PWM generator from a free-running count; duty via valid/ready, applied only at period wrap.
// Latency: cnt -> pwm_out / period_start is 1 cycle. Backpressure: one pending duty slot, duty_ready low while full.
// Optional PWM_PERIOD_COUNT_EN adds a saturating period_cnt output.
module pwm_from_count #(
    parameter int WIDTH = 24,
    parameter int RES   = 8,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt,
    input  logic             en,
    input  logic [RES:0]     duty,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             active
`ifdef PWM_PERIOD_COUNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    localparam logic [RES:0] DUTY_MAX = {1'b1, {RES{1'b0}}};

    state_t         state;
    logic [RES-1:0] phase;
    logic [RES-1:0] phase_q;
    logic [RES:0]   duty_cur;
    logic [RES:0]   duty_pend;
    logic [RES:0]   duty_sat;
    logic [RES:0]   eff_duty;
    logic           pend_full;
    logic           wrap;
    logic           xfer;
    logic           apply;
    logic           hit;

    assign phase      = cnt[SHIFT+RES-1:SHIFT];
    assign wrap       = (phase < phase_q);
    assign duty_ready = ~pend_full;
    assign xfer       = duty_valid & ~pend_full;
    assign duty_sat   = (duty > DUTY_MAX) ? DUTY_MAX : duty;
    assign apply      = wrap & (state != IDLE);
    // On the wrap cycle duty_cur is still the old value, so compare against the one being loaded.
    assign eff_duty   = wrap ? duty_pend : duty_cur;
    assign hit        = ({1'b0, phase} < eff_duty);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            phase_q      <= '0;
            duty_cur     <= '0;
            duty_pend    <= '0;
            pend_full    <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            active       <= 1'b0;
        end else begin
            phase_q      <= phase;
            period_start <= wrap;

            if (apply) begin
                duty_cur <= duty_pend;
            end
            // A transfer landing on the wrap cycle is held for the following wrap.
            if (xfer) begin
                duty_pend <= duty_sat;
                pend_full <= 1'b1;
            end else if (apply) begin
                pend_full <= 1'b0;
            end

            pwm_out <= 1'b0;
            active  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (wrap) begin
                        state   <= RUN;
                        active  <= 1'b1;
                        pwm_out <= hit;
                    end
                end
                RUN: begin
                    pwm_out <= hit;
                    active  <= 1'b1;
                    if (!en) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    pwm_out <= hit;
                    if (en) begin
                        state  <= RUN;
                        active <= 1'b1;
                    end else if (wrap) begin
                        state <= IDLE;
                    end else begin
                        active <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PWM_PERIOD_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (state == IDLE && en) begin
            period_cnt <= '0;
        end else if (wrap && active && period_cnt != 16'hFFFF) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_from_count.sv
// Directed bench for pwm_from_count at RES=4: vector table for reset/start-up, hand sequences for multi-period cases.
module tb_pwm_from_count;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] cnt;
    logic        en;
    logic [4:0]  duty;
    logic        duty_valid;
    logic        duty_ready;
    logic        pwm_out;
    logic        period_start;
    logic        active;
`ifdef PWM_PERIOD_COUNT_EN
    logic [15:0] period_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    pwm_from_count #(.WIDTH(12), .RES(4), .SHIFT(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .cnt          (cnt),
        .en           (en),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .active       (active)
`ifdef PWM_PERIOD_COUNT_EN
        ,
        .period_cnt   (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic en;
        int   c;
        int   d;
        logic dv;
        logic pwm;
        logic ps;
        logic act;
        logic rdy;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic r, logic e, int c, int d, logic dv,
                                logic p, logic s, logic a, logic y);
        vec_t v;
        v.rst = r; v.en = e; v.c = c; v.d = d; v.dv = dv;
        v.pwm = p; v.ps = s; v.act = a; v.rdy = y;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act_v, input logic exp_v);
        nvec++;
        if (act_v !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0b expected %0b (cnt=%0d)", nm, act_v, exp_v, cnt);
        end
    endtask

    // Runs one 16-step period starting at phase 0; optionally offers a duty at step offer_at.
    task automatic run_period(input int d, input int offer_at, input int offer_val, input string nm);
        automatic int de = (d > 16) ? 16 : d;
        for (int i = 0; i < 16; i++) begin
            cnt        = cnt + 12'd1;
            duty_valid = (i == offer_at);
            duty       = 5'(offer_val);
            tick();
            chk({nm, "_pwm"}, pwm_out, (cnt[3:0] < de));
            chk({nm, "_ps"}, period_start, (cnt[3:0] == 4'd0));
            if (i == offer_at) chk({nm, "_rdy"}, duty_ready, 1'b0);
        end
        duty_valid = 1'b0;
    endtask

    initial begin
        int hi;
        reset = 1'b1; en = 1'b0; cnt = '0; duty = '0; duty_valid = 1'b0;

        //          rst   en    cnt d  dv    pwm   ps    act   rdy
        tbl[0]  = mk(1'b1, 1'b0, 0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[1]  = mk(1'b1, 1'b0, 1,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b1, 1'b0, 2,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 3,  4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 4,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 15, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 16, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[7]  = mk(1'b0, 1'b1, 17, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[8]  = mk(1'b0, 1'b1, 19, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[9]  = mk(1'b0, 1'b1, 20, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[10] = mk(1'b0, 1'b1, 31, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tbl[11] = mk(1'b0, 1'b1, 32, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            reset      = tbl[i].rst;
            en         = tbl[i].en;
            cnt        = 12'(tbl[i].c);
            duty       = 5'(tbl[i].d);
            duty_valid = tbl[i].dv;
            tick();
            chk($sformatf("v%0d_pwm", i), pwm_out, tbl[i].pwm);
            chk($sformatf("v%0d_ps", i), period_start, tbl[i].ps);
            chk($sformatf("v%0d_act", i), active, tbl[i].act);
            chk($sformatf("v%0d_rdy", i), duty_ready, tbl[i].rdy);
        end

        // Steady duty=4: high exactly 4 of 16 steps.
        hi = 0;
        for (int c = 33; c < 64; c++) begin
            cnt = 12'(c);
            tick();
            chk("run4_pwm", pwm_out, ((c % 16) < 4));
            chk("run4_ps", period_start, ((c % 16) == 0));
            if (c >= 48 && pwm_out) hi++;
        end
        chk("run4_highcount", (hi == 4), 1'b1);

        // Duty 16 offered on the wrap cycle must wait a period; then 16, 31 (saturates), 0.
        run_period(4, 0, 16, "t3a");
        run_period(16, 3, 31, "t3b");
        run_period(31, 3, 0, "t3c");
        run_period(0, -1, 0, "t3d");

        // 10 accepted mid-period; 2 stalls until the following wrap, then lands one period later.
        for (int c = 128; c < 160; c++) begin
            cnt        = 12'(c);
            duty_valid = (c >= 130 && c <= 145);
            duty       = (c == 130) ? 5'd10 : 5'd2;
            tick();
            if (c >= 130 && c <= 143) chk("t4_stall_rdy", duty_ready, 1'b0);
            if (c == 144) chk("t4_wrap_rdy", duty_ready, 1'b1);
            if (c == 145) chk("t4_accept2_rdy", duty_ready, 1'b0);
            chk("t4_pwm", pwm_out, (c >= 144) ? ((c % 16) < 10) : 1'b0);
        end
        duty_valid = 1'b0;
        run_period(2, -1, 0, "t4b");

        // en low at phase 5: period completes, then idle; later a brief drop inside DRAIN resumes RUN.
        for (int c = 176; c < 240; c++) begin
            cnt = 12'(c);
            en  = !((c >= 181 && c <= 192) || (c >= 213 && c <= 215));
            tick();
            chk("t5_ps", period_start, ((c % 16) == 0));
            chk("t5_act", active, (c < 192) || (c >= 208));
            if (c != 192) chk("t5_pwm", pwm_out, (c < 192 || c >= 208) ? ((c % 16) < 2) : 1'b0);
        end

        // Load duty 8 and leave 5 pending, then reset at phase 2 while pwm_out is high.
        en = 1'b1;
        for (int c = 240; c < 258; c++) begin
            cnt        = 12'(c);
            duty_valid = (c == 243) || (c == 257);
            duty       = (c == 243) ? 5'd8 : 5'd5;
            tick();
            chk("t6_pwm", pwm_out, (c >= 256) ? 1'b1 : ((c % 16) < 2));
        end
        duty_valid = 1'b0;
        chk("t6_pend_rdy", duty_ready, 1'b0);
        reset = 1'b1;
        cnt   = 12'd258;
        tick();
        chk("t6_rst_pwm", pwm_out, 1'b0);
        chk("t6_rst_rdy", duty_ready, 1'b1);
        chk("t6_rst_act", active, 1'b0);
        reset = 1'b0;
        en    = 1'b0;
        cnt   = 12'd7;
        for (int i = 0; i < 6; i++) begin
            en = (i >= 4);
            tick();
            chk("t6_stall_ps", period_start, 1'b0);
            chk("t6_stall_act", active, 1'b0);
            chk("t6_stall_pwm", pwm_out, 1'b0);
            chk("t6_stall_rdy", duty_ready, 1'b1);
        end
        // Discarded pending duty: restart must run at duty 0.
        for (int c = 8; c < 32; c++) begin
            cnt = 12'(c);
            tick();
            chk("t6_re_ps", period_start, (c == 16));
            chk("t6_re_act", active, (c >= 16));
            chk("t6_re_pwm", pwm_out, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
